i2s_stereo_controller: RTL and testbench
========================================

Name: i2s_stereo_controller

Overview:
- Full-duplex stereo I2S master for the CS5343 ADC and CS4344 DAC on the I2S2 Pmod.
- Generalises the mono controller:
  - both left and right channels
  - parametrised data and slot widths
  - valid/ready DAC handshake with a holding buffer
  - frame-aligned simultaneous stereo ADC output
- Sits between the Pmod pins and the filter datapath.
- Generates mclk, sclk and lrck from clk.

Parameters:
- ClockConfigWidth, 4, width of the clockConfig divider input
- DataWidth, 16, parallel sample width per channel, 2..SerialDataWidth
- SerialDataWidth, 24, data bits carried per channel slot, DataWidth..31

Ports:
- clk  in  1  system clock
- resetN  in  1  synchronous, active-low reset
- clockConfig  in  ClockConfigWidth  mclk divider; F_mclk = F_clk/((clockConfig+1)*2)
- adcLeft  out  DataWidth  signed left sample
- adcRight  out  DataWidth  signed right sample
- adcValid  out  1  one-clk pulse, new stereo pair
- dacLeft  in  DataWidth  signed left sample
- dacRight  in  DataWidth  signed right sample
- dacValid  in  1  DAC pair offered
- dacReady  out  1  holding buffer empty
- dacUnderrun  out  1  sticky underrun flag (see Optional Feature)
- mclk, sclk, lrck  out  1 each  I2S clocks
- adc  in  1  serial ADC data, asynchronous
- dac  out  1  serial DAC data

Behaviour:
- Reset values: all outputs 0; dacReady 1; all counters and buffers cleared.
- Reset mid-frame aborts the frame; nothing partial is emitted.
- Clocking:
  - mclk toggles every clockConfig+1 clks.
  - sclk = mclk/4.
  - lrck = sclk/64; lrck low means left slot, high means right slot.
  - lrck toggles on an sclk falling edge.
- Slot bit index k=0..31:
  - k=0 is the sclk period starting at the lrck edge; k increments on each sclk falling edge.
  - k=1..DataWidth carry sample bits MSB first (I2S one-bit delay).
  - All other indices carry 0 on dac.
- Two-flop synchroniser on adc. Capture occurs on the internal sclk-rising-edge pulse.
  - In slot index k=1..DataWidth, shift into the channel shift register.
  - Bits DataWidth+1..SerialDataWidth are ignored (truncation, no rounding).
- dac changes only on the internal sclk-falling-edge pulse.
  - At index k it drives shift[DataWidth-k].
- Frame = left slot then right slot, starting at an lrck falling edge.
  - The partial slot after reset release is not a frame: no capture, dac = 0.
- adcValid:
  - Pulses 1 clk, 1 cycle after the right-slot k=DataWidth capture.
  - adcLeft and adcRight update in that same cycle and hold until the next pulse.
- DAC handshake:
  - Transfer when dacValid && dacReady. Data goes to holding; dacReady drops the next cycle.
  - dacValid without dacReady is ignored; the source must hold the pair.
- At each frame start (lrck falling pulse):
  - If holding is full: move to the transmit pair; dacReady rises next cycle.
  - If holding is empty: underrun rule applies.
- Acceptance in the same cycle as a frame start lands in holding for the next frame; the current frame takes the underrun rule.
- State machine:
  - WAIT_FRAME → LEFT on the first lrck falling pulse.
  - LEFT → RIGHT on the lrck rising pulse.
  - RIGHT → LEFT on the lrck falling pulse.
  - Any state → WAIT_FRAME on reset.
- Changing clockConfig mid-operation is undefined; change it only while held in reset.

Optional Feature:
- Macro I2S_UNDERRUN_DETECT_EN.
- Defined:
  - Underrun transmits zeros for both channels for that frame.
  - dacUnderrun sets and stays 1 until reset.
- Undefined:
  - Underrun retransmits the last transmitted pair (zeros after reset).
  - dacUnderrun is tied 0.

Test Plan:
- Reset, clockConfig=0:
  - mclk period 2 clk, sclk 8 clk, lrck 512 clk.
  - First lrck rise at clk 256 after release.
  - All outputs 0 during reset.
- ADC loopback-free stimulus: model drives left=0x123456, right=0xFEDCBA (24-bit).
  - Expect adcLeft=0x1234, adcRight=0xFEDC, DataWidth=16.
  - adcValid exactly one clk per 512.
- DAC: offer dacLeft=0x8001, dacRight=0x7FFE before frame start.
  - dacReady drops next cycle, rises after frame start.
  - Serial bits k=1..16 match MSB first; k=0 and k=17..31 are 0.
- Simultaneous event: dacValid asserted in the frame-start cycle with holding empty.
  - Pair is sent in the following frame; the current frame follows the underrun rule.
- Underrun:
  - With the macro: zeros sent and dacUnderrun=1 and sticky.
  - Without the macro: last pair repeated and dacUnderrun=0.
- Reset asserted mid-right-slot: no adcValid pulse; dac 0; dacReady 1; the next frame starts at the first lrck falling edge.

Source files
------------

// File: rtl/i2s_stereo_controller.sv
// Full-duplex stereo I2S master (CS5343 ADC / CS4344 DAC) with valid/ready DAC holding buffer.
// Optional macro I2S_UNDERRUN_DETECT_EN: underrun sends zeros and sets a sticky dacUnderrun flag.
module i2s_stereo_controller #(
    parameter int ClockConfigWidth = 4,
    parameter int DataWidth        = 16,
    parameter int SerialDataWidth  = 24
) (
    input  logic                        clk,
    input  logic                        resetN,
    input  logic [ClockConfigWidth-1:0] clockConfig,
    output logic signed [DataWidth-1:0] adcLeft,
    output logic signed [DataWidth-1:0] adcRight,
    output logic                        adcValid,
    input  logic signed [DataWidth-1:0] dacLeft,
    input  logic signed [DataWidth-1:0] dacRight,
    input  logic                        dacValid,
    output logic                        dacReady,
    output logic                        dacUnderrun,
    output logic                        mclk,
    output logic                        sclk,
    output logic                        lrck,
    input  logic                        adc,
    output logic                        dac
);
    typedef enum logic [1:0] {WAIT_FRAME, LEFT, RIGHT} stateT;

    localparam logic [4:0] LastBit = 5'(DataWidth);
    localparam logic [4:0] SlotBits = 5'(SerialDataWidth);

    stateT                 state;
    logic [ClockConfigWidth-1:0] divCnt;
    logic [8:0]            phase;
    logic [8:0]            phaseNext;
    logic                  tick, sclkRise, sclkFall, frameStart, lrckRise;
    logic [4:0]            slotIdx, nextIdx;
    logic                  adcMeta, adcSync, capDone, holdFull, underrunFlag;
    logic [DataWidth-1:0]  shLeft, shRight, holdLeft, holdRight, txLeft, txRight, txShift;

    // One 9-bit phase counter advanced per mclk half-period derives every I2S clock.
    assign tick       = (divCnt == clockConfig);
    assign phaseNext  = phase + 9'd1;
    assign sclkRise   = tick && (phase[2:0] == 3'd3);
    assign sclkFall   = tick && (phase[2:0] == 3'd7);
    assign frameStart = tick && (phase == 9'd511);
    assign lrckRise   = tick && (phase == 9'd255);
    assign slotIdx    = phase[7:3];
    assign nextIdx    = phaseNext[7:3];

    assign mclk        = phase[0];
    assign sclk        = phase[2];
    assign lrck        = phase[8];
    assign dacReady    = !holdFull;
    assign dacUnderrun = underrunFlag;

    always_ff @(posedge clk) begin
        if (!resetN) begin
            state        <= WAIT_FRAME;
            divCnt       <= '0;
            phase        <= '0;
            adcMeta      <= 1'b0;
            adcSync      <= 1'b0;
            capDone      <= 1'b0;
            holdFull     <= 1'b0;
            underrunFlag <= 1'b0;
            shLeft       <= '0;
            shRight      <= '0;
            holdLeft     <= '0;
            holdRight    <= '0;
            txLeft       <= '0;
            txRight      <= '0;
            txShift      <= '0;
            adcLeft      <= '0;
            adcRight     <= '0;
            adcValid     <= 1'b0;
            dac          <= 1'b0;
        end else begin
            adcMeta  <= adc;
            adcSync  <= adcMeta;
            adcValid <= 1'b0;
            divCnt   <= tick ? '0 : divCnt + 1'b1;
            if (tick)
                phase <= phaseNext;

            // A pair accepted in the frame-start cycle is held for the following frame.
            if (frameStart) begin
                if (holdFull) begin
                    txLeft   <= holdLeft;
                    txRight  <= holdRight;
                    holdFull <= 1'b0;
                end else begin
`ifdef I2S_UNDERRUN_DETECT_EN
                    txLeft       <= '0;
                    txRight      <= '0;
                    underrunFlag <= 1'b1;
`endif
                    if (dacValid) begin
                        holdLeft  <= dacLeft;
                        holdRight <= dacRight;
                        holdFull  <= 1'b1;
                    end
                end
            end else if (dacValid && !holdFull) begin
                holdLeft  <= dacLeft;
                holdRight <= dacRight;
                holdFull  <= 1'b1;
            end

            case (state)
                WAIT_FRAME: if (frameStart) state <= LEFT;
                LEFT:       if (lrckRise)   state <= RIGHT;
                RIGHT:      if (frameStart) state <= LEFT;
                default:                    state <= WAIT_FRAME;
            endcase

            if (sclkFall) begin
                if (state != WAIT_FRAME && nextIdx == 5'd1) begin
                    dac     <= phase[8] ? txRight[DataWidth-1] : txLeft[DataWidth-1];
                    txShift <= (phase[8] ? txRight : txLeft) << 1;
                end else if (state != WAIT_FRAME && nextIdx >= 5'd2 && nextIdx <= LastBit) begin
                    dac     <= txShift[DataWidth-1];
                    txShift <= txShift << 1;
                end else begin
                    dac <= 1'b0;
                end
            end

            // Bits past DataWidth in the slot are dropped, which truncates the sample.
            if (sclkRise && state != WAIT_FRAME && slotIdx >= 5'd1 && slotIdx <= LastBit
                    && slotIdx <= SlotBits) begin
                if (phase[8])
                    shRight <= {shRight[DataWidth-2:0], adcSync};
                else
                    shLeft  <= {shLeft[DataWidth-2:0], adcSync};
            end

            capDone <= sclkRise && state == RIGHT && slotIdx == LastBit;
            if (capDone) begin
                adcValid <= 1'b1;
                adcLeft  <= shLeft;
                adcRight <= shRight;
            end
        end
    end
endmodule

// File: tb/tb_i2s_stereo_controller.sv
// Directed bench for i2s_stereo_controller: clocks, ADC capture, DAC handshake, underrun, reset abort.
module tb_i2s_stereo_controller;
`ifdef I2S_UNDERRUN_DETECT_EN
    localparam bit UndEn = 1'b1;
`else
    localparam bit UndEn = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        resetN;
    logic [3:0]  clockConfig;
    logic [15:0] adcLeft, adcRight, dacLeft, dacRight;
    logic        adcValid, dacValid, dacReady, dacUnderrun;
    logic        mclk, sclk, lrck, adc, dac;

    int errors = 0;
    int checks = 0;
    int cyc = 0;
    logic [15:0] vldL[$], vldR[$];
    int          vldCyc[$];
    logic [31:0] frmL[$], frmR[$];

    i2s_stereo_controller dut (
        .clk(clk), .resetN(resetN), .clockConfig(clockConfig),
        .adcLeft(adcLeft), .adcRight(adcRight), .adcValid(adcValid),
        .dacLeft(dacLeft), .dacRight(dacRight), .dacValid(dacValid),
        .dacReady(dacReady), .dacUnderrun(dacUnderrun),
        .mclk(mclk), .sclk(sclk), .lrck(lrck), .adc(adc), .dac(dac)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h want %h", tag, act, exp);
        end
    endtask

    task automatic stepTo(input int t);
        int guard = 0;
        while (cyc < t && guard < 5000) begin
            @(negedge clk);
            guard++;
        end
    endtask

    function automatic logic [31:0] slotOf(input logic [15:0] s);
        return {1'b0, s, 15'b0};
    endfunction

    task automatic checkFrame(input int j, input logic [15:0] l, input logic [15:0] r);
        if (frmL.size() > j) begin
            chk($sformatf("frame%0d.L", j), frmL[j], slotOf(l));
            chk($sformatf("frame%0d.R", j), frmR[j], slotOf(r));
        end else
            chk($sformatf("frame%0d.exists", j), frmL.size(), j + 1);
    endtask

    // I2S slave models: ADC drives MSB-first after the one-bit delay, DAC bits collected per slot.
    initial begin
        int k = 0;
        logic prevSclk = 1'b0, prevLr = 1'b0, inRst;
        logic [31:0] word = '0, curL = '0;
        logic [23:0] src;
        adc = 1'b0;
        forever begin
            @(posedge clk);
            inRst = !resetN;
            if (inRst) cyc = 0; else cyc++;
            @(negedge clk);
            if (inRst) begin
                k = 0; prevSclk = 1'b0; prevLr = 1'b0; word = '0; curL = '0; adc = 1'b0;
            end else begin
                if (adcValid) begin
                    vldL.push_back(adcLeft); vldR.push_back(adcRight); vldCyc.push_back(cyc);
                end
                if (prevSclk && !sclk) begin
                    if (lrck != prevLr) begin
                        if (lrck) curL = word;
                        else begin frmL.push_back(curL); frmR.push_back(word); end
                        k = 0; word = '0;
                    end else k++;
                    src = lrck ? 24'hFEDCBA : 24'h123456;
                    adc = (k >= 1 && k <= 24) ? src[24-k] : 1'b0;
                end
                if (!prevSclk && sclk && k < 32) word[31-k] = dac;
                prevSclk = sclk; prevLr = lrck;
            end
        end
    end

    initial begin
        int mism = 0, firstRise = 0, mT = 0, sT = 0;
        logic pm, ps;
        resetN = 1'b0; clockConfig = 4'd0; dacValid = 1'b0; dacLeft = '0; dacRight = '0;
        repeat (4) @(negedge clk);
        chk("rst.mclk", mclk, 0);  chk("rst.sclk", sclk, 0);  chk("rst.lrck", lrck, 0);
        chk("rst.dac", dac, 0);    chk("rst.adcValid", adcValid, 0);
        chk("rst.adcLeft", adcLeft, 0); chk("rst.adcRight", adcRight, 0);
        chk("rst.dacReady", dacReady, 1); chk("rst.dacUnderrun", dacUnderrun, 0);

        resetN = 1'b1;
        for (int i = 0; i < 600; i++) begin
            @(negedge clk);
            if (mclk !== 1'(cyc % 2) || sclk !== 1'((cyc / 4) % 2) || lrck !== 1'((cyc / 256) % 2))
                mism++;
            if (lrck && firstRise == 0) firstRise = cyc;
        end
        chk("clkPhase", mism, 0);
        chk("lrckFirstRise", firstRise, 256);

        chk("rdyIdle", dacReady, 1);
        dacValid = 1'b1; dacLeft = 16'h8001; dacRight = 16'h7FFE;
        @(negedge clk);
        dacValid = 1'b0;
        chk("rdyDrop", dacReady, 0);
        stepTo(1023); chk("rdyHeld", dacReady, 0);
        stepTo(1024); chk("rdyRise", dacReady, 1);

        stepTo(1535);
        dacValid = 1'b1; dacLeft = 16'h1357; dacRight = 16'hE8CA;
        @(negedge clk);
        dacValid = 1'b0;
        chk("rdySimAccept", dacReady, 0);
        stepTo(2048); chk("rdySimRelease", dacReady, 1);
        stepTo(3080);

        checkFrame(0, 16'h0, 16'h0);
        checkFrame(1, 16'h0, 16'h0);
        checkFrame(2, 16'h8001, 16'h7FFE);
        checkFrame(3, UndEn ? 16'h0 : 16'h8001, UndEn ? 16'h0 : 16'h7FFE);
        checkFrame(4, 16'h1357, 16'hE8CA);
        checkFrame(5, UndEn ? 16'h0 : 16'h1357, UndEn ? 16'h0 : 16'hE8CA);
        chk("underrunFlag", dacUnderrun, 32'(UndEn));

        chk("adcPulseCount", vldCyc.size(), 5);
        for (int i = 0; i < vldCyc.size(); i++) begin
            chk($sformatf("adcCyc%0d", i), vldCyc[i], 901 + 512 * i);
            chk($sformatf("adcLeft%0d", i), vldL[i], 16'h1234);
            chk($sformatf("adcRight%0d", i), vldR[i], 16'hFEDC);
        end

        // Reset in the middle of a right slot with a pair waiting in holding.
        stepTo(3372);
        dacValid = 1'b1; dacLeft = 16'h0F0F; dacRight = 16'hF0F0;
        @(negedge clk);
        dacValid = 1'b0;
        chk("preRstReady", dacReady, 0);
        vldL.delete(); vldR.delete(); vldCyc.delete(); frmL.delete(); frmR.delete();
        resetN = 1'b0;
        repeat (3) @(negedge clk);
        chk("midRst.dac", dac, 0);         chk("midRst.dacReady", dacReady, 1);
        chk("midRst.adcValid", adcValid, 0); chk("midRst.adcLeft", adcLeft, 0);
        chk("midRst.underrun", dacUnderrun, 0);
        resetN = 1'b1;
        stepTo(1030);
        chk("postRst.pulseCount", vldCyc.size(), 1);
        if (vldCyc.size() > 0) chk("postRst.pulseCyc", vldCyc[0], 901);
        checkFrame(0, 16'h0, 16'h0);
        checkFrame(1, 16'h0, 16'h0);

        // Divider: clockConfig=2 gives an mclk toggle every 3 clk and an sclk toggle every 12.
        resetN = 1'b0; clockConfig = 4'd2;
        repeat (3) @(negedge clk);
        resetN = 1'b1;
        pm = mclk; ps = sclk;
        for (int i = 0; i < 60; i++) begin
            @(negedge clk);
            if (mclk !== pm) mT++;
            if (sclk !== ps) sT++;
            pm = mclk; ps = sclk;
        end
        chk("div.mclkToggles", mT, 20);
        chk("div.sclkToggles", sT, 5);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
